// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and helpers for the VGA pipeline
// (controller, sprite and ROM stages all import this package).
package vga_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FP      = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BP      = 48;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FP      = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BP      = 33;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int unsigned CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    // True when v lies in the half-open window [lo, lo + len); computed one
    // bit wider so lo + len can never wrap.
    function automatic logic in_window(input cnt_t v, input cnt_t lo, input cnt_t len);
        logic [CNT_W:0] hi;
        hi = {1'b0, lo} + {1'b0, len};
        return (v >= lo) && ({1'b0, v} < hi);
    endfunction

endpackage

// File: rtl/vga_controller.sv
// VGA timing generator: pixel/line counters plus registered sync, blank,
// line_end and frame_start. Every output is registered from the next-count
// values, so it always describes the DrawX/DrawY shown in the same cycle.
// Segment widths default to the shared package values; overriding them is
// only meant for reduced-size frames.
module vga_controller
    import vga_pkg::*;
#(
    parameter int unsigned H_VIS_P  = H_VISIBLE,
    parameter int unsigned H_FP_P   = H_FP,
    parameter int unsigned H_SYNC_P = H_SYNC,
    parameter int unsigned H_BP_P   = H_BP,
    parameter int unsigned V_VIS_P  = V_VISIBLE,
    parameter int unsigned V_FP_P   = V_FP,
    parameter int unsigned V_SYNC_P = V_SYNC,
    parameter int unsigned V_BP_P   = V_BP
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    input  logic             pix_en,
    output logic             hs,
    output logic             vs,
    output logic             blank,
    output logic [CNT_W-1:0] DrawX,
    output logic [CNT_W-1:0] DrawY,
    output logic             frame_start,
    output logic             line_end
);

    localparam int unsigned H_TOT_P = H_VIS_P + H_FP_P + H_SYNC_P + H_BP_P;
    localparam int unsigned V_TOT_P = V_VIS_P + V_FP_P + V_SYNC_P + V_BP_P;

    localparam cnt_t CNT_ZERO     = {CNT_W{1'b0}};
    localparam cnt_t CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam cnt_t H_LAST       = cnt_t'(H_TOT_P - 32'd1);
    localparam cnt_t V_LAST       = cnt_t'(V_TOT_P - 32'd1);
    localparam cnt_t H_VIS_C      = cnt_t'(H_VIS_P);
    localparam cnt_t V_VIS_C      = cnt_t'(V_VIS_P);
    localparam cnt_t H_SYNC_START = cnt_t'(H_VIS_P + H_FP_P);
    localparam cnt_t H_SYNC_LEN   = cnt_t'(H_SYNC_P);
    localparam cnt_t V_SYNC_START = cnt_t'(V_VIS_P + V_FP_P);
    localparam cnt_t V_SYNC_LEN   = cnt_t'(V_SYNC_P);

    cnt_t x_r;
    cnt_t y_r;
    cnt_t x_next_s;
    cnt_t y_next_s;
    logic frame_wrap_s;
    logic hs_r;
    logic vs_r;
    logic blank_r;
    logic line_end_r;
    logic frame_start_r;

    // Next-count computation; '>=' on the last value folds any stray
    // out-of-range count straight back to zero.
    always_comb begin
        x_next_s     = x_r;
        y_next_s     = y_r;
        frame_wrap_s = 1'b0;
        if (pix_en) begin
            if (x_r >= H_LAST) begin
                x_next_s = CNT_ZERO;
                if (y_r >= V_LAST) begin
                    y_next_s     = CNT_ZERO;
                    frame_wrap_s = 1'b1;
                end else begin
                    y_next_s = y_r + CNT_ONE;
                end
            end else begin
                x_next_s = x_r + CNT_ONE;
                y_next_s = y_r;
            end
        end else begin
            x_next_s = x_r;
            y_next_s = y_r;
        end
    end

    // Horizontal pixel counter.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            x_r <= CNT_ZERO;
        end else begin
            x_r <= x_next_s;
        end
    end

    // Vertical line counter.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            y_r <= CNT_ZERO;
        end else begin
            y_r <= y_next_s;
        end
    end

    // Sync/blank/line_end decoded from the next counts so they line up with the counters.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_r       <= 1'b1;
            vs_r       <= 1'b1;
            blank_r    <= 1'b1;
            line_end_r <= 1'b0;
        end else begin
            hs_r       <= ~in_window(x_next_s, H_SYNC_START, H_SYNC_LEN);
            vs_r       <= ~in_window(y_next_s, V_SYNC_START, V_SYNC_LEN);
            blank_r    <= (x_next_s < H_VIS_C) && (y_next_s < V_VIS_C);
            line_end_r <= (x_next_s == H_LAST);
        end
    end

    // Single-cycle pulse while (0,0) is shown right after a frame wrap; it is
    // not held when pix_en stalls, so it never stretches beyond one cycle.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= frame_wrap_s;
        end
    end

    assign DrawX       = x_r;
    assign DrawY       = y_r;
    assign hs          = hs_r;
    assign vs          = vs_r;
    assign blank       = blank_r;
    assign line_end    = line_end_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_controller.sv
// Self-checking bench for vga_controller. A full-size instance and a
// short-frame instance (8 lines) share the stimulus, so frame wrap, vsync
// and frame_start are reached within a short run. The model derives all
// outputs from the number of pixel advances since reset.
module tb_vga_controller;

    logic       vga_clk = 1'b0;
    logic       reset_n;
    logic       pix_en;

    logic       hs_f, vs_f, blank_f, fs_f, le_f;
    logic [9:0] dx_f, dy_f;
    logic       hs_s, vs_s, blank_s, fs_s, le_s;
    logic [9:0] dx_s, dy_s;

    int n_checks = 0;
    int n_fail   = 0;
    int adv_n;          // pixel advances since reset
    logic adv_last;     // previous edge advanced the counters
    logic cmp_en = 1'b0;

    always #5 vga_clk = ~vga_clk;

    vga_controller u_full (
        .vga_clk(vga_clk), .reset_n(reset_n), .pix_en(pix_en),
        .hs(hs_f), .vs(vs_f), .blank(blank_f), .DrawX(dx_f), .DrawY(dy_f),
        .frame_start(fs_f), .line_end(le_f)
    );

    vga_controller #(.V_VIS_P(4), .V_FP_P(1), .V_SYNC_P(2), .V_BP_P(1)) u_small (
        .vga_clk(vga_clk), .reset_n(reset_n), .pix_en(pix_en),
        .hs(hs_s), .vs(vs_s), .blank(blank_s), .DrawX(dx_s), .DrawY(dy_s),
        .frame_start(fs_s), .line_end(le_s)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance counter model.
    always @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            adv_n    <= 0;
            adv_last <= 1'b0;
        end else begin
            adv_last <= pix_en;
            if (pix_en) adv_n <= adv_n + 1;
        end
    end

    task automatic check_dut(input string tag, input int vvis, input int vfp, input int vsync,
                             input int vtot, input int dx, input int dy, input logic h,
                             input logic v, input logic b, input logic le, input logic fs);
        int x, y;
        x = adv_n % 800;
        y = (adv_n / 800) % vtot;
        check({tag, ".DrawX"}, dx, x);
        check({tag, ".DrawY"}, dy, y);
        check({tag, ".hs"}, int'(h), (x >= 656 && x <= 751) ? 0 : 1);
        check({tag, ".vs"}, int'(v), (y >= vvis + vfp && y < vvis + vfp + vsync) ? 0 : 1);
        check({tag, ".blank"}, int'(b), (x < 640 && y < vvis) ? 1 : 0);
        check({tag, ".line_end"}, int'(le), (x == 799) ? 1 : 0);
        check({tag, ".frame_start"}, int'(fs),
              (adv_last && adv_n > 0 && adv_n % (800 * vtot) == 0) ? 1 : 0);
        check({tag, ".range"}, int'(dx <= 799 && dy < vtot), 1);
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge vga_clk) begin
        if (cmp_en) begin
            check_dut("full", 480, 10, 2, 525, int'(dx_f), int'(dy_f), hs_f, vs_f, blank_f, le_f, fs_f);
            check_dut("small", 4, 1, 2, 8, int'(dx_s), int'(dy_s), hs_s, vs_s, blank_s, le_s, fs_s);
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, ".f.DrawX"}, int'(dx_f), 0);
        check({tag, ".f.DrawY"}, int'(dy_f), 0);
        check({tag, ".f.hs"}, int'(hs_f), 1);
        check({tag, ".f.vs"}, int'(vs_f), 1);
        check({tag, ".f.blank"}, int'(blank_f), 1);
        check({tag, ".f.line_end"}, int'(le_f), 0);
        check({tag, ".f.frame_start"}, int'(fs_f), 0);
        check({tag, ".s.DrawX"}, int'(dx_s), 0);
        check({tag, ".s.DrawY"}, int'(dy_s), 0);
        check({tag, ".s.frame_start"}, int'(fs_s), 0);
    endtask

    initial begin
        int hs_low, blank_hi, le_hi, vs_low, fs_cnt, first_hs;
        reset_n = 1'b0;
        pix_en  = 1'b1;
        repeat (3) @(negedge vga_clk);
        check_reset_values("reset");
        cmp_en = 1'b1;

        // One full line at one pixel per clock.
        reset_n = 1'b1;
        hs_low = 0; blank_hi = 0; le_hi = 0; first_hs = -1;
        for (int c = 1; c <= 800; c++) begin
            @(negedge vga_clk);
            if (!hs_f) begin
                if (first_hs < 0) first_hs = int'(dx_f);
                hs_low++;
            end
            if (blank_f) blank_hi++;
            if (le_f) begin
                le_hi++;
                check("line_end_at_799", int'(dx_f), 799);
            end
        end
        check("line1.DrawX", int'(dx_f), 0);
        check("line1.DrawY", int'(dy_f), 1);
        check("line1.hs_low_cycles", hs_low, 96);
        check("line1.hs_first_x", first_hs, 656);
        check("line1.blank_cycles", blank_hi, 640);
        check("line1.line_end_cycles", le_hi, 1);

        // Alternating pix_en: one line spans 1600 clocks.
        hs_low = 0; le_hi = 0;
        for (int c = 1; c <= 1600; c++) begin
            @(negedge vga_clk);
            if (!hs_f) hs_low++;
            if (le_f) le_hi++;
            pix_en = ~pix_en;
        end
        check("toggle.DrawX", int'(dx_f), 0);
        check("toggle.DrawY", int'(dy_f), 2);
        check("toggle.hs_low_cycles", hs_low, 192);
        check("toggle.line_end_cycles", le_hi, 2);

        // Run to (700,2), then reset asynchronously between edges.
        pix_en = 1'b1;
        repeat (700) @(negedge vga_clk);
        check("pre_rst.DrawX", int'(dx_f), 700);
        check("pre_rst.DrawY", int'(dy_f), 2);
        #2 reset_n = 1'b0;
        #1 check_reset_values("async_rst");
        repeat (2) @(negedge vga_clk);
        reset_n = 1'b1;
        @(negedge vga_clk);
        check("restart.DrawX", int'(dx_f), 1);
        check("restart.DrawY", int'(dy_f), 0);
        check("restart.frame_start", int'(fs_f), 0);

        // One complete short frame (6400 advances since reset) plus one.
        vs_low = 0; fs_cnt = 0;
        for (int c = 2; c <= 6401; c++) begin
            @(negedge vga_clk);
            if (!vs_s) vs_low++;
            if (fs_s) begin
                fs_cnt++;
                check("small.fs_at_origin", int'({dx_s, dy_s}), 0);
            end
            if (c == 6400) check("small.wrap_pulse", int'(fs_s), 1);
        end
        check("small.vs_low_cycles", vs_low, 1600);
        check("small.frame_start_count", fs_cnt, 1);
        check("full.DrawY_after_6401", int'(dy_f), 8);
        check("full.DrawX_after_6401", int'(dx_f), 1);

        // Random pix_en over roughly three short frames.
        for (int c = 0; c < 27000; c++) begin
            @(negedge vga_clk);
            pix_en = ($urandom_range(0, 3) != 0);
        end
        @(negedge vga_clk);
        cmp_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
